crossbar_master: RTL

- Initiator end of the crossbar point-to-point bus (req/cmd/addr/wdata/ack/rdata).
- Accepts read and write commands from a local client into a small command FIFO.
- Issues the commands one at a time on the bus and waits for ack. For reads, it captures rdata and returns one response per command.
- Sits between a client (CPU/DMA stub) and one crossbar slave port.

---
 rtl/crossbar_pkg.sv | 22 ++
 rtl/crossbar_master_sync_fifo.sv | 66 ++++++
 rtl/crossbar_master.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/crossbar_pkg.sv
// Shared widths, master state encoding and command payload for the crossbar initiator.
package crossbar_pkg;

  localparam int unsigned ADDR_W = 31;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2,
    REC  = 2'd3
  } mstate_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/crossbar_master_sync_fifo.sv
// sync_fifo: power-of-two depth FIFO with registered full/empty and a combinational head read.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is legal only when a pop frees a slot in the same cycle.
  assign do_push = push && (!full_q || pop);
  assign do_pop  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/crossbar_master.sv
// Crossbar bus initiator: queues client commands and issues them one at a time on req/ack.
// Optional REQ timeout abort enabled by defining CROSSBAR_MASTER_TIMEOUT_EN.
module crossbar_master
  import crossbar_pkg::*;
#(
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              req,
  output logic              cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              ack,
  input  logic [DATA_W-1:0] rdata
);

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("crossbar_master: QDEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
  end

  mstate_e           state_q, state_d;
  logic              req_q, req_d;
  logic              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  cmd_t push_cmd, head_cmd;
  logic fifo_full, fifo_empty;
  logic push, pop;
  logic timeout_c;
  logic abort;

  assign push_cmd  = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (push_cmd),
    .rdata_c (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef CROSSBAR_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             abort_q, abort_d;
  logic             rsp_err_q, rsp_err_d;

  // Counter is cleared while idle, so it starts from zero on every REQ entry.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    abort_d   = abort_q;
    rsp_err_d = rsp_err_q;
    timeout_c = 1'b0;
    if (state_q == IDLE) begin
      tmo_cnt_d = '0;
      abort_d   = 1'b0;
    end else if (state_q == REQ && !ack) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      timeout_c = (tmo_cnt_d == TMO_W'(TIMEOUT_CYC));
      abort_d   = timeout_c;
    end
    if (state_q == CAPT) rsp_err_d = abort_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      abort_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      abort_q   <= abort_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign abort   = abort_q;
  assign rsp_err = rsp_err_q;
`else
  assign timeout_c = 1'b0;
  assign abort     = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // Next-state and registered bus/response outputs.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = head_cmd.we;
          addr_d  = head_cmd.addr;
          wdata_d = head_cmd.wdata;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // ack takes priority over a coincident timeout.
        if (ack || timeout_c) begin
          req_d   = 1'b0;
          state_d = CAPT;
        end
      end
      CAPT: begin
        rsp_valid_d = 1'b1;
        rsp_we_d    = cmd_q;
        rsp_rdata_d = (cmd_q || abort) ? '0 : rdata;
        state_d     = REC;
      end
      REC: begin
        if (!ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      cmd_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req       = req_q;
  assign cmd       = cmd_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
